// File: rtl/or4_sweep_ctrl.sv
// Self-test sequencer for the 4-input OR gate: sweeps all 16 input vectors, samples and scores outputs.
// Optional OR4_SWEEP_LOOP_EN: continuous mode (wrap 15->0, done pulses on the final sample, err_cnt saturates).
module or4_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  output logic       drv_d,
  input  logic       obs_e,
  input  logic       obs_f,
  input  logic       obs_g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_err_vec,
  output logic       first_err_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        vec, vec_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic [4:0]        err_nx;
  logic [3:0]        fev_nx;
  logic              fvalid_nx;
  logic              pass_nx;
  logic              run_err, run_err_nx;
  logic              busy_nx;
  logic              done_nx;
  logic [3:0]        drv_nx;
  logic [2:0]        expect_obs;
  logic              mismatch;

  assign expect_obs = {|vec, vec[3] | vec[2], vec[1] | vec[0]};
  assign mismatch   = ({obs_g, obs_f, obs_e} != expect_obs);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx   = state;
    vec_nx     = vec;
    hold_nx    = hold;
    err_nx     = err_cnt;
    fev_nx     = first_err_vec;
    fvalid_nx  = first_err_valid;
    pass_nx    = pass;
    run_err_nx = run_err;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx   = S_DRIVE;
          vec_nx     = 4'd0;
          hold_nx    = '0;
          err_nx     = 5'd0;
          fvalid_nx  = 1'b0;
          pass_nx    = 1'b0;
          run_err_nx = 1'b0;
        end
      end

      S_DRIVE: begin
        if (abort) begin
          state_nx = S_IDLE;
          pass_nx  = 1'b0;
        end else begin
          hold_nx = hold + 1'b1;
          if (hold == HOLD_LAST) state_nx = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (abort) begin
          state_nx = S_IDLE;
          pass_nx  = 1'b0;
        end else begin
          if (mismatch) begin
            err_nx     = (err_cnt == 5'd31) ? err_cnt : err_cnt + 5'd1;
            run_err_nx = 1'b1;
            if (!first_err_valid) begin
              fev_nx    = vec;
              fvalid_nx = 1'b1;
            end
          end
          if (vec == 4'd15) begin
            // run_err tracks only the sweep now ending, so pass reflects this sweep alone
            pass_nx    = !(run_err || mismatch);
            run_err_nx = 1'b0;
`ifdef OR4_SWEEP_LOOP_EN
            state_nx = S_DRIVE;
            vec_nx   = 4'd0;
            hold_nx  = '0;
`else
            state_nx = S_DONE;
`endif
          end else begin
            state_nx = S_DRIVE;
            vec_nx   = vec + 4'd1;
            hold_nx  = '0;
          end
        end
      end

      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx == S_DRIVE) || (state_nx == S_SAMPLE);
    drv_nx  = busy_nx ? vec_nx : 4'd0;
`ifdef OR4_SWEEP_LOOP_EN
    done_nx = (state_nx == S_SAMPLE) && (vec_nx == 4'd15);
`else
    done_nx = (state_nx == S_DONE);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                      <= S_IDLE;
      vec                        <= 4'd0;
      hold                       <= '0;
      err_cnt                    <= 5'd0;
      first_err_vec              <= 4'd0;
      first_err_valid            <= 1'b0;
      pass                       <= 1'b0;
      run_err                    <= 1'b0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      {drv_d, drv_c, drv_b, drv_a} <= 4'd0;
    end else begin
      state                      <= state_nx;
      vec                        <= vec_nx;
      hold                       <= hold_nx;
      err_cnt                    <= err_nx;
      first_err_vec              <= fev_nx;
      first_err_valid            <= fvalid_nx;
      pass                       <= pass_nx;
      run_err                    <= run_err_nx;
      busy                       <= busy_nx;
      done                       <= done_nx;
      {drv_d, drv_c, drv_b, drv_a} <= drv_nx;
    end
  end

endmodule
